// File: rtl/ahb_bus_arbiter_if.sv
// AHB arbitration bundle: per-manager request/lock lines, the shared-bus
// transfer qualifiers the arbiter observes, and the grant/ownership outputs.
// The slave modport is the arbiter's view; the master modport is the
// requesters'/bus side.
interface ahb_bus_arbiter_if #(
    parameter int NUM_MASTERS   = 4,
    parameter int HMASTER_WIDTH = 4
);
    logic [NUM_MASTERS-1:0]   hbusreq;
    logic [NUM_MASTERS-1:0]   hlock;
    logic [1:0]               htrans;
    logic [2:0]               hburst;
    logic                     hready;
    logic [NUM_MASTERS-1:0]   hgrant;
    logic [HMASTER_WIDTH-1:0] hmaster;
    logic                     hmastlock;

    modport master (
        output hbusreq, hlock, htrans, hburst, hready,
        input  hgrant, hmaster, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready,
        output hgrant, hmaster, hmastlock
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Multi-manager AHB arbiter: registered one-hot grant, round-robin fairness,
// burst-aware handover and locked-sequence support. hmaster/hmastlock follow
// the grant once the transfer in flight completes.
// Optional feature macro: AHB_ARB_INCR_TIMEOUT_EN limits how many SEQ beats
// an undefined-length INCR burst may run while other managers are waiting.
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int HMASTER_WIDTH  = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_INCR_BEATS = 16
) (
    input logic       hclk,
    input logic       hreset,
    ahb_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {PARK = 2'd0, OWN = 2'd1, LOCKED = 2'd2} state_t;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_INCR   = 3'b001;
    localparam logic [NUM_MASTERS-1:0] DEFAULT_OH = NUM_MASTERS'(1) << DEFAULT_MASTER;

    state_t                   state, state_nxt;
    logic [NUM_MASTERS-1:0]   grant, grant_nxt;
    logic [HMASTER_WIDTH-1:0] ptr, ptr_nxt;
    logic [3:0]               beat_cnt;
    logic [HMASTER_WIDTH-1:0] hmaster_q;
    logic                     hmastlock_q;
    logic                     owner_req, owner_lock, rearb, force_rearb;
    logic [NUM_MASTERS-1:0]   req_elig, win_oh;
    logic [HMASTER_WIDTH-1:0] win_idx;
    logic                     found;

    function automatic logic [HMASTER_WIDTH-1:0] encode(input logic [NUM_MASTERS-1:0] oh);
        logic [HMASTER_WIDTH-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (oh[i]) idx = HMASTER_WIDTH'(i);
        return idx;
    endfunction

    // Remaining SEQ beats after the NONSEQ of a fixed-length burst (WRAPn/INCRn share a length).
    function automatic logic [3:0] burst_len(input logic [2:0] burst);
        case (burst[2:1])
            2'b00:   return 4'd0;
            2'b01:   return 4'd3;
            2'b10:   return 4'd7;
            default: return 4'd15;
        endcase
    endfunction

    assign owner_req  = |(bus.hbusreq & grant);
    assign owner_lock = |(bus.hlock & grant);

`ifdef AHB_ARB_INCR_TIMEOUT_EN
    localparam int ICW = $clog2(MAX_INCR_BEATS + 1);
    logic [ICW-1:0] incr_cnt;

    assign force_rearb = bus.hready && bus.htrans == T_SEQ && bus.hburst == B_INCR &&
                         incr_cnt >= ICW'(MAX_INCR_BEATS - 1) &&
                         |(bus.hbusreq & ~grant) && state != LOCKED && !owner_lock;

    // Count completed SEQ beats of an undefined-length INCR; restart on any new burst or handover.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            incr_cnt <= '0;
        end else if (bus.hready) begin
            if (bus.htrans == T_NONSEQ || bus.htrans == T_IDLE || force_rearb)
                incr_cnt <= '0;
            else if (bus.htrans == T_SEQ && bus.hburst == B_INCR &&
                     incr_cnt < ICW'(MAX_INCR_BEATS))
                incr_cnt <= incr_cnt + 1'b1;
        end
    end
`else
    logic unused_max_incr;
    assign unused_max_incr = (MAX_INCR_BEATS > 0);
    assign force_rearb     = 1'b0;
`endif

    assign rearb = bus.hready && (
                       bus.htrans == T_IDLE ||
                       (bus.htrans == T_NONSEQ && bus.hburst == B_SINGLE) ||
                       (bus.htrans == T_SEQ && beat_cnt == 4'd1) ||
                       (bus.hburst == B_INCR && !owner_req) ||
                       force_rearb);

    // A forced handover must not hand the bus straight back to the current owner.
    assign req_elig = force_rearb ? (bus.hbusreq & ~grant) : bus.hbusreq;

    // Round-robin search: nearest requester after the pointer, wrapping, pointer itself last.
    always_comb begin
        win_oh  = '0;
        win_idx = ptr;
        found   = 1'b0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (ptr == HMASTER_WIDTH'(j)) begin
                for (int k = NUM_MASTERS; k >= 1; k--) begin
                    if (req_elig[(j + k) % NUM_MASTERS]) begin
                        win_oh                          = '0;
                        win_oh[(j + k) % NUM_MASTERS]   = 1'b1;
                        win_idx                         = HMASTER_WIDTH'((j + k) % NUM_MASTERS);
                        found                           = 1'b1;
                    end
                end
            end
        end
    end

    // Next grant/state: decisions are only taken at a rearbitration point.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ptr_nxt   = ptr;
        if (rearb) begin
            if (owner_lock) begin
                state_nxt = LOCKED;
            end else if (found) begin
                grant_nxt = win_oh;
                ptr_nxt   = win_idx;
                state_nxt = OWN;
            end else begin
                grant_nxt = DEFAULT_OH;
                state_nxt = PARK;
            end
        end
    end

    // Arbitration state, grant and round-robin pointer registers.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state <= PARK;
            grant <= DEFAULT_OH;
            ptr   <= HMASTER_WIDTH'(DEFAULT_MASTER);
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Fixed-length burst beat tracking on completed transfers; BUSY holds.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            beat_cnt <= 4'd0;
        end else if (bus.hready) begin
            case (bus.htrans)
                T_NONSEQ: beat_cnt <= burst_len(bus.hburst);
                T_SEQ:    if (beat_cnt != 4'd0) beat_cnt <= beat_cnt - 1'b1;
                T_IDLE:   beat_cnt <= 4'd0;
                default:  beat_cnt <= beat_cnt;
            endcase
        end
    end

    // Address-phase ownership follows the grant at the next completed transfer.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            hmaster_q   <= HMASTER_WIDTH'(DEFAULT_MASTER);
            hmastlock_q <= 1'b0;
        end else if (bus.hready) begin
            hmaster_q   <= encode(grant);
            hmastlock_q <= owner_lock && (state == LOCKED);
        end
    end

    assign bus.hgrant    = grant;
    assign bus.hmaster   = hmaster_q;
    assign bus.hmastlock = hmastlock_q;
endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
Multi-manager AHB bus arbiter. Shares one AHB address/data path between NUM_MASTERS requesters. Registered one-hot grant, round-robin fairness, burst-aware handover and locked-transfer support. Drives HMASTER and HMASTLOCK to the shared-bus mux and to the bus monitor.

Parameters:
NUM_MASTERS, 4, number of requesting managers (2..16)
HMASTER_WIDTH, 4, width of hmaster output; must satisfy 2**HMASTER_WIDTH >= NUM_MASTERS
DEFAULT_MASTER, 0, parked manager index when no requests are pending
MAX_INCR_BEATS, 16, beat limit for undefined-length INCR (optional feature only)

Ports:
hclk  input  1  bus clock; all state updates on rising edge
hreset  input  1  asynchronous, active-high reset
hbusreq  input  NUM_MASTERS  per-manager bus request
hlock  input  NUM_MASTERS  per-manager locked-sequence request
htrans  input  2  transfer type on shared bus (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
hburst  input  3  burst type on shared bus (SINGLE=000 … INCR16=111)
hready  input  1  combined transfer-completion
hgrant  output  NUM_MASTERS  one-hot registered grant
hmaster  output  HMASTER_WIDTH  index of manager owning the address phase
hmastlock  output  1  current address phase is locked

Behaviour:
- Reset (async, hreset=1): hgrant = one-hot DEFAULT_MASTER; hmaster = DEFAULT_MASTER; hmastlock = 0; beat counter = 0; round-robin pointer = DEFAULT_MASTER; state = PARK.
- States: PARK (no requests, default owner), OWN (unlocked ownership), LOCKED (owner holds hlock).
- Beat counter tracks remaining beats of current fixed-length burst:
  - on hready=1 & htrans=NONSEQ: load len-1 (SINGLE/INCR 0; WRAP4/INCR4 3; WRAP8/INCR8 7; WRAP16/INCR16 15);
  - on hready=1 & htrans=SEQ & counter>0: decrement;
  - BUSY: hold.
- Rearbitration point (REARB) = hready=1 AND any of:
  - htrans=IDLE;
  - NONSEQ with hburst=SINGLE;
  - SEQ with counter==1 (last beat of a fixed burst);
  - hburst=INCR and the owner's hbusreq=0.
- Early termination: NONSEQ/IDLE mid-burst reloads the counter; treated as a REARB per the rules above.
- Grant selection at REARB:
  - Owner's hlock=1 → keep grant, go to or stay in LOCKED.
  - Else first requester searching (pointer+1) mod NUM_MASTERS upward, wrapping; pointer updates to the winner.
  - No requester → grant DEFAULT_MASTER, PARK.
  - Owner requesting alone → keeps grant.
- No REARB → hgrant holds (including hready=0 wait states).
- LOCKED exits at the first REARB where the owner's hlock=0, then arbitrates normally.
- hgrant changes one cycle after the REARB cycle (registered).
- hmaster/hmastlock update on the first rising edge with hready=1 after a grant change:
  - hmaster = encoded hgrant;
  - hmastlock = hlock[granted] & LOCKED.
  - Ownership of the address phase therefore lags hgrant by one completed transfer.
- Simultaneous: new request arriving in the REARB cycle is eligible. hbusreq deasserted in the REARB cycle is ignored.
- hgrant is always exactly one-hot; hmaster < NUM_MASTERS always.

Optional Feature:
AHB_ARB_INCR_TIMEOUT_EN:
- Defined: a beat counter counts completed SEQ beats of an undefined-length INCR burst. At MAX_INCR_BEATS completed beats, if any other manager requests and the owner is not LOCKED, force a REARB; the owner loses grant and must restart with NONSEQ.
- Undefined: INCR bursts hold the grant indefinitely while the owner's hbusreq=1.

Test Plan:
- Reset mid-burst: assert hreset during an INCR8 from m2 → hgrant=0001, hmaster=0, hmastlock=0 immediately; no pointer carry-over.
- Round-robin: hbusreq=1111, all SINGLE NONSEQ, hready=1 → grant sequence m1,m2,m3,m0,m1 from reset pointer 0.
- Burst hold: m1 owns INCR4 with one hready=0 wait on beat 2; m3 requests → hgrant stays 0010 until SEQ beat 4 completes, then 1000 next cycle; hmaster=3 one ready transfer later.
- Lock: m2 asserts hlock+hbusreq over two INCR4 bursts, m0 requesting → m2 retains grant, hmastlock=1 throughout; m0 granted after m2 drops hlock at next REARB.
- Parking: hbusreq drops to 0000 after m3 SINGLE → hgrant=0001 (DEFAULT_MASTER=0), state PARK.
- With AHB_ARB_INCR_TIMEOUT_EN, MAX_INCR_BEATS=16: m0 INCR for 40 beats, m1 requesting → grant moves to m1 after 16th SEQ beat; without macro → m0 keeps grant for all 40.
